// File: rtl/sequencia_arbiter.sv
// Round-robin owner of a single Sequencia serial pattern detector.
// Each granted job clears, loads, starts and feeds the detector, then reports found and cycle count.
module sequencia_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_palavra,
  input  logic [N_REQ-1:0]   req_bit,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               found,
  output logic [7:0]         match_cycles,
  output logic               det_rst_n,
  output logic               det_setar_palavra,
  output logic [7:0]         det_palavra,
  output logic               det_start,
  output logic               det_bit_in,
  input  logic               det_encontrado
);

  localparam int               IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0]    PTR_RST  = IW'(N_REQ - 1);
  localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, SEARCH, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      word_q, word_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic            found_q, found_d;
  logic [7:0]      match_cycles_q, match_cycles_d;
  logic            det_rst_n_q, det_rst_n_d;
  logic            det_setar_palavra_q, det_setar_palavra_d;
  logic [7:0]      det_palavra_q, det_palavra_d;
  logic            det_start_q, det_start_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      pick_word;
  logic            owner_req;

  // First requester after the pointer, with wrap-around
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_word  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!pick_valid && req[j] && (((int'(ptr_q) + i) % N_REQ) == j)) begin
          pick_valid = 1'b1;
          pick_idx   = IW'(j);
          pick_word  = req_palavra[8*j +: 8];
        end
      end
    end
  end

  assign owner_req = req[idx_q];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    ptr_d          = ptr_q;
    word_d         = word_q;
    cnt_d          = cnt_q;
    found_d        = found_q;
    match_cycles_d = match_cycles_q;
    det_palavra_d  = det_palavra_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          word_d  = pick_word;
          state_d = CLEAR;
        end
      end
      CLEAR:  state_d = owner_req ? LOAD : IDLE;
      LOAD:   state_d = owner_req ? START : IDLE;
      START: begin
        cnt_d   = '0;
        state_d = owner_req ? SEARCH : IDLE;
      end
      SEARCH: begin
        cnt_d = cnt_q + 8'd1;
        // A dropped request aborts silently; a match beats a simultaneous timeout
        if (!owner_req) begin
          state_d = IDLE;
        end else if (det_encontrado || (cnt_q == CNT_LAST)) begin
          state_d        = DONE;
          found_d        = det_encontrado;
          match_cycles_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    grant_d             = (state_d == IDLE) ? '0 : (ONE_HOT0 << idx_d);
    done_d              = (state_d == DONE) ? (ONE_HOT0 << idx_d) : '0;
    det_rst_n_d         = (state_d != CLEAR);
    det_setar_palavra_d = (state_d == LOAD);
    det_start_d         = (state_d == START);
    if (state_d == LOAD) begin
      det_palavra_d = word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      idx_q               <= '0;
      ptr_q               <= PTR_RST;
      word_q              <= '0;
      cnt_q               <= '0;
      grant_q             <= '0;
      done_q              <= '0;
      found_q             <= 1'b0;
      match_cycles_q      <= '0;
      det_rst_n_q         <= 1'b0;
      det_setar_palavra_q <= 1'b0;
      det_palavra_q       <= '0;
      det_start_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      idx_q               <= idx_d;
      ptr_q               <= ptr_d;
      word_q              <= word_d;
      cnt_q               <= cnt_d;
      grant_q             <= grant_d;
      done_q              <= done_d;
      found_q             <= found_d;
      match_cycles_q      <= match_cycles_d;
      det_rst_n_q         <= det_rst_n_d;
      det_setar_palavra_q <= det_setar_palavra_d;
      det_palavra_q       <= det_palavra_d;
      det_start_q         <= det_start_d;
    end
  end

  // Serial data passes straight through so the detector sees each bit in its own cycle
  always_comb begin
    det_bit_in = 1'b0;
    if (state_q == SEARCH) begin
      det_bit_in = req_bit[idx_q];
    end
  end

  assign grant             = grant_q;
  assign done              = done_q;
  assign found             = found_q;
  assign match_cycles      = match_cycles_q;
  assign det_rst_n         = det_rst_n_q;
  assign det_setar_palavra = det_setar_palavra_q;
  assign det_palavra       = det_palavra_q;
  assign det_start         = det_start_q;

endmodule

// File: tb/tb_sequencia_arbiter.sv
// Directed bench for sequencia_arbiter: two instances (TIMEOUT 64 and 10), each fed by a
// small behavioural Sequencia detector that shifts det_bit_in and flags a sticky match.
module tb_sequencia_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [3:0]  req, reqBit, grant, done;
  logic [31:0] reqPalavra;
  logic        found, detRstN, detSetar, detStart, detBitIn, detEncontrado;
  logic [7:0]  matchCycles, detPalavra;

  logic [3:0]  reqB, reqBitB, grantB, doneB;
  logic [31:0] reqPalavraB;
  logic        foundB, detRstNB, detSetarB, detStartB, detBitInB, detEncontradoB;
  logic [7:0]  matchCyclesB, detPalavraB;

  int vectors = 0;
  int fails = 0;

  sequencia_arbiter #(.N_REQ(4), .TIMEOUT(64)) dutA (
    .clk(clk), .rst_n(rstN), .req(req), .req_palavra(reqPalavra), .req_bit(reqBit),
    .grant(grant), .done(done), .found(found), .match_cycles(matchCycles),
    .det_rst_n(detRstN), .det_setar_palavra(detSetar), .det_palavra(detPalavra),
    .det_start(detStart), .det_bit_in(detBitIn), .det_encontrado(detEncontrado)
  );

  sequencia_arbiter #(.N_REQ(4), .TIMEOUT(10)) dutB (
    .clk(clk), .rst_n(rstN), .req(reqB), .req_palavra(reqPalavraB), .req_bit(reqBitB),
    .grant(grantB), .done(doneB), .found(foundB), .match_cycles(matchCyclesB),
    .det_rst_n(detRstNB), .det_setar_palavra(detSetarB), .det_palavra(detPalavraB),
    .det_start(detStartB), .det_bit_in(detBitInB), .det_encontrado(detEncontradoB)
  );

  // Detector model for instance A: match is raised the cycle after the last pattern bit
  logic [7:0] modShA, modPalA;
  logic       modActA;
  always @(posedge clk) begin
    if (!detRstN) begin
      modShA <= 8'h00; modPalA <= 8'h00; modActA <= 1'b0; detEncontrado <= 1'b0;
    end else begin
      if (detSetar) modPalA <= detPalavra;
      if (detStart) modActA <= 1'b1;
      if (modActA) begin
        modShA <= {modShA[6:0], detBitIn};
        if ({modShA[6:0], detBitIn} == modPalA) detEncontrado <= 1'b1;
      end
    end
  end

  // Identical detector model for instance B
  logic [7:0] modShB, modPalB;
  logic       modActB;
  always @(posedge clk) begin
    if (!detRstNB) begin
      modShB <= 8'h00; modPalB <= 8'h00; modActB <= 1'b0; detEncontradoB <= 1'b0;
    end else begin
      if (detSetarB) modPalB <= detPalavraB;
      if (detStartB) modActB <= 1'b1;
      if (modActB) begin
        modShB <= {modShB[6:0], detBitInB};
        if ({modShB[6:0], detBitInB} == modPalB) detEncontradoB <= 1'b1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] w, input logic [3:0] b);
    req        = r;
    reqPalavra = w;
    reqBit     = b;
  endtask

  task automatic waitDoneA(input int bound, output int n);
    n = 0;
    while (done == 4'b0000 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_found"}, 32'(found), 32'h0);
    checkOutput({tag, "_cycles"}, 32'(matchCycles), 32'h0);
    checkOutput({tag, "_det_rst_n"}, 32'(detRstN), 32'h0);
    checkOutput({tag, "_setar"}, 32'(detSetar), 32'h0);
    checkOutput({tag, "_palavra"}, 32'(detPalavra), 32'h0);
    checkOutput({tag, "_start"}, 32'(detStart), 32'h0);
    checkOutput({tag, "_bit_in"}, 32'(detBitIn), 32'h0);
  endtask

  task automatic applyReset;
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  logic [7:0] patA5 = 8'hA5;
  logic [3:0] expOrder [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int n;

  initial begin
    applyStimulus(4'b0000, 32'h0, 4'b0000);
    reqB = 4'b0000; reqPalavraB = 32'h0; reqBitB = 4'b0000;
    rstN = 1'b0;
    tick();
    tick();
    checkResetA("reset");
    rstN = 1'b1;

    $display("[TB] single job, word A5");
    applyStimulus(4'b0001, 32'h0000_00A5, 4'b0000);
    tick();
    checkOutput("t1_clear_grant", 32'(grant), 32'h1);
    checkOutput("t1_clear_det_rst_n", 32'(detRstN), 32'h0);
    tick();
    checkOutput("t1_load_setar", 32'(detSetar), 32'h1);
    checkOutput("t1_load_palavra", 32'(detPalavra), 32'hA5);
    checkOutput("t1_load_det_rst_n", 32'(detRstN), 32'h1);
    tick();
    checkOutput("t1_start", 32'(detStart), 32'h1);
    tick();
    for (int k = 0; k < 8; k++) begin
      reqBit[0] = patA5[7-k];
      #1;
      checkOutput("t1_bit_in", 32'(detBitIn), 32'(patA5[7-k]));
      tick();
    end
    reqBit = 4'b0000;
    checkOutput("t1_no_early_done", 32'(done), 32'h0);
    tick();
    checkOutput("t1_done", 32'(done), 32'h1);
    checkOutput("t1_found", 32'(found), 32'h1);
    checkOutput("t1_cycles_in_range", 32'(matchCycles >= 8'd8 && matchCycles <= 8'd10), 32'h1);
    applyStimulus(4'b0000, 32'h0, 4'b0000);
    tick();
    checkOutput("t1_idle_grant", 32'(grant), 32'h0);
    checkOutput("t1_idle_done", 32'(done), 32'h0);

    $display("[TB] timeout, requester 1");
    applyStimulus(4'b0010, 32'h0000_FF00, 4'b0000);
    tick();
    checkOutput("t2_grant", 32'(grant), 32'h2);
    tick();
    tick();
    checkOutput("t2_start", 32'(detStart), 32'h1);
    waitDoneA(100, n);
    checkOutput("t2_cycles_to_done", 32'(n), 32'd65);
    checkOutput("t2_done", 32'(done), 32'h2);
    checkOutput("t2_found", 32'(found), 32'h0);
    checkOutput("t2_cycles", 32'(matchCycles), 32'd64);
    applyStimulus(4'b0000, 32'h0, 4'b0000);
    tick();

    $display("[TB] round robin");
    applyReset();
    applyStimulus(4'b1111, 32'h0, 4'b0000);
    for (int j = 0; j < 5; j++) begin
      tick();
      checkOutput("t3_grant", 32'(grant), 32'(expOrder[j]));
      waitDoneA(20, n);
      checkOutput("t3_done", 32'(done), 32'(expOrder[j]));
      checkOutput("t3_found", 32'(found), 32'h1);
      checkOutput("t3_cycles", 32'(matchCycles), 32'd2);
      tick();
      checkOutput("t3_idle_gap", 32'(grant), 32'h0);
      checkOutput("t3_single_pulse", 32'(done), 32'h0);
    end
    applyStimulus(4'b0000, 32'h0, 4'b0000);

    $display("[TB] abort on requester 2");
    applyStimulus(4'b1100, 32'h00FF_0000, 4'b0000);
    tick();
    checkOutput("t4_grant2", 32'(grant), 32'h4);
    for (int k = 0; k < 7; k++) tick();
    applyStimulus(4'b1000, 32'h00FF_0000, 4'b0000);
    tick();
    checkOutput("t4_abort_grant", 32'(grant), 32'h0);
    checkOutput("t4_abort_done", 32'(done), 32'h0);
    checkOutput("t4_found_kept", 32'(found), 32'h1);
    checkOutput("t4_cycles_kept", 32'(matchCycles), 32'd2);
    tick();
    checkOutput("t4_grant3", 32'(grant), 32'h8);
    waitDoneA(20, n);
    checkOutput("t4_done3", 32'(done), 32'h8);
    applyStimulus(4'b0000, 32'h0, 4'b0000);
    tick();

    $display("[TB] match and timeout together, TIMEOUT 10");
    reqB = 4'b0001; reqPalavraB = 32'h0000_0001; reqBitB = 4'b0000;
    tick();
    checkOutput("t5_grant", 32'(grantB), 32'h1);
    tick();
    tick();
    tick();
    for (int k = 1; k <= 10; k++) begin
      reqBitB[0] = (k == 9);
      tick();
    end
    reqBitB = 4'b0000;
    checkOutput("t5_done", 32'(doneB), 32'h1);
    checkOutput("t5_found", 32'(foundB), 32'h1);
    checkOutput("t5_cycles", 32'(matchCyclesB), 32'd10);
    reqB = 4'b0000;
    tick();

    $display("[TB] reset during search");
    applyStimulus(4'b0001, 32'h0000_00FF, 4'b0000);
    for (int k = 0; k < 6; k++) tick();
    checkOutput("t6_busy_grant", 32'(grant), 32'h1);
    rstN = 1'b0;
    tick();
    checkResetA("t6_reset");
    rstN = 1'b1;
    tick();
    checkOutput("t6_regrant", 32'(grant), 32'h1);
    applyStimulus(4'b0000, 32'h0, 4'b0000);
    tick();
    checkOutput("t6_drop_grant", 32'(grant), 32'h0);
    checkOutput("t6_drop_done", 32'(done), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
